control_botones_ajuste: RTL and testbench
=========================================

// Module: control_botones_ajuste
// PURPOSE
//  Front-panel input conditioner and field-navigation FSM feeding the 2-digit adjust counters.
//  - Synchronizes and debounces five push-buttons.
//  - Tracks which time/date/timer field is being edited.
//  - Emits en_count field codes plus single-cycle enUP/enDOWN pulses, with hold-to-repeat.
//  - Sits between the board buttons and every contador_*_2dig instance.
// PARAMETERS
//  DEB_CYCLES  1_000_000   consecutive stable samples needed to accept a level (10 ms @100 MHz)
//  REP_DELAY   50_000_000  cycles a held up/down waits before auto-repeat starts (500 ms)
//  REP_PERIOD  20_000_000  cycles between auto-repeat pulses (200 ms)
//  N_FIELDS    9           number of editable fields; field codes 1..N_FIELDS (max 15)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-low reset
//  btn_up     in   1  raw button, increment (asynchronous, bouncy)
//  btn_down   in   1  raw button, decrement
//  btn_left   in   1  raw button, previous field
//  btn_right  in   1  raw button, next field
//  btn_mode   in   1  raw button, enter/leave adjust mode
//  en_count   out  4  field code being edited; 0 = no field (not adjusting)
//  enUP       out  1  one-cycle increment pulse
//  enDOWN     out  1  one-cycle decrement pulse
//  adj_mode   out  1  1 while in ADJUST state
// BEHAVIOUR
//  - Reset (reset==0, async)
//    - All outputs 0; FSM = IDLE; field = 1.
//    - Debounced levels = 0; repeat counter cleared.
//    - Leaving reset does not produce pulses for buttons already held; a fresh release+press is required.
//  - Input path, per button
//    - 2-FF synchronizer, then debounce counter.
//    - Debounced level flips only after DEB_CYCLES consecutive samples differing from it; any equal sample clears the count.
//    - press = debounced rising edge, 1 cycle.
//    - Latency from a clean input edge to the registered effect: 2 + DEB_CYCLES + 1 cycles.
//  - FSM: IDLE / ADJUST
//    - IDLE: en_count = 0; up, down, left and right are ignored.
//      - mode press -> ADJUST with field = 1.
//    - ADJUST: en_count = field.
//      - right press: field + 1, wrapping N_FIELDS -> 1.
//      - left press: field - 1, wrapping 1 -> N_FIELDS.
//      - left and right pressed in the same cycle: no change.
//      - mode press -> IDLE, en_count = 0.
//      - mode wins over any press in the same cycle.
//  - Up/down pulses (ADJUST only)
//    - Registered outputs, high exactly 1 cycle, always separated by at least 1 low cycle.
//    - Downstream counters edge-detect these pulses.
//    - Press -> pulse on the next cycle.
//    - If still held: next pulse REP_DELAY cycles after the first, then every REP_PERIOD cycles until release.
//    - Both debounced up and down high: no pulses, repeat counter held at 0. Releasing one does not restart; a new press is required.
//    - Pulses issued on a field change are issued for the new field; en_count updates in the same cycle as the field register.
//    - A pulse never coincides with en_count = 0.
//    - Exiting ADJUST while up/down is held aborts repeat immediately.
//  - Width rules
//    - Debounce and repeat counters are sized with $clog2 of their parameter.
//    - The repeat counter saturates; it never wraps.
// STRUCTURE
//  - Shared package (panel_pkg)
//    - Field-code localparams: FLD_NONE = 0, FLD_MIN = 1; 9 = timer minutes, matching the counter decode.
//    - FSM state encoding: IDLE = 1'b0, ADJUST = 1'b1.
//  - Sub-module antirrebote_boton (sync + debounce + press pulse, DEB_CYCLES parameter)
//    - Instantiated 5 times.
//    - FSM, field register and repeat timer live in the top.
// TESTING  (DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=5, N_FIELDS=9)
//  1. Drop reset mid-run with adj_mode=1, en_count=5, up held -> all outputs 0 without a clk edge; after release, no pulse until up is released and re-pressed.
//  2. btn_mode glitches high for 3 cycles twice, then held 10 cycles -> glitches ignored; one transition to adj_mode=1, en_count=1.
//  3. In ADJUST at field 1: 9 right presses -> en_count 2,3..9,1. Then 1 left press -> en_count 9.
//  4. In ADJUST: hold btn_up 60 cycles past debounce -> enUP pulses at t0, t0+20, +25, +30, ... until release; enDOWN stays 0.
//  5. In ADJUST: assert up and down together, held 60 cycles -> zero pulses; release down only -> still zero pulses.
//  6. In IDLE: press up, down, left, right -> en_count=0, no pulses. Mode and right pressed in the same cycle from ADJUST -> IDLE, field unchanged.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel adjust logic: field codes,
// navigation FSM states and the up/down repeat direction.
package panel_pkg;

    localparam logic [3:0] FLD_NONE      = 4'd0;
    localparam logic [3:0] FLD_MIN       = 4'd1;
    localparam logic [3:0] FLD_TIMER_MIN = 4'd9;

    typedef enum logic {
        IDLE   = 1'b0,
        ADJUST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

endpackage

// File: rtl/antirrebote_boton.sv
// One push-button conditioner: 2-FF synchronizer, counting debouncer and
// a single-cycle press pulse on the debounced rising edge.
module antirrebote_boton #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [1:0]    sync_vld;
    logic          deb;
    logic          armed;
    logic          level_q;
    logic [CW-1:0] cnt;

    // A button already held when reset is released must be seen released
    // (debounced low with a real synchronized sample) before it may press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            sync_vld <= 2'b00;
            deb      <= 1'b0;
            armed    <= 1'b0;
            level_q  <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_a   <= btn;
            sync_b   <= sync_a;
            sync_vld <= {sync_vld[0], 1'b1};
            level_q  <= level;
            if (sync_b == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync_b;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (sync_vld[1] && !sync_b && !deb) begin
                armed <= 1'b1;
            end
        end
    end

    assign level = deb & armed;
    assign press = level & ~level_q;

endmodule

// File: rtl/control_botones_ajuste.sv
// Front-panel adjust controller: conditions five buttons, walks the editable
// fields and issues up/down pulses with hold-to-repeat to the adjust counters.
module control_botones_ajuste
    import panel_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int REP_DELAY  = 50_000_000,
    parameter int REP_PERIOD = 20_000_000,
    parameter int N_FIELDS   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_mode,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       adj_mode
);

    localparam int RW = (REP_DELAY > 1) ? $clog2(REP_DELAY) : 1;
    localparam logic [RW-1:0] REP_LAST   = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REP_DELAY - REP_PERIOD);
    localparam logic [3:0]    FLD_LAST   = 4'(N_FIELDS);

    logic [4:0] raw;
    logic [4:0] lvl;
    logic [4:0] prs;

    assign raw = {btn_mode, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        antirrebote_boton #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .btn   (raw[i]),
            .level (lvl[i]),
            .press (prs[i])
        );
    end

    logic up_lvl, down_lvl;
    logic up_press, down_press, left_press, right_press, mode_press;

    assign up_lvl      = lvl[0];
    assign down_lvl    = lvl[1];
    assign up_press    = prs[0];
    assign down_press  = prs[1];
    assign left_press  = prs[2];
    assign right_press = prs[3];
    assign mode_press  = prs[4];

    state_t        state, state_n;
    dir_t          dir, dir_n;
    logic [3:0]    field, field_n;
    logic [RW-1:0] rep_cnt, rep_n;
    logic          up_n, down_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dir     <= DIR_NONE;
            field   <= FLD_MIN;
            rep_cnt <= '0;
            enUP    <= 1'b0;
            enDOWN  <= 1'b0;
        end else begin
            state   <= state_n;
            dir     <= dir_n;
            field   <= field_n;
            rep_cnt <= rep_n;
            enUP    <= up_n;
            enDOWN  <= down_n;
        end
    end

    // The repeat counter tracks cycles since the last pulse and is reloaded
    // at each pulse, so it only ever counts up to REP_DELAY-1.
    always_comb begin
        state_n = state;
        dir_n   = dir;
        field_n = field;
        rep_n   = rep_cnt;
        up_n    = 1'b0;
        down_n  = 1'b0;
        case (state)
            IDLE: begin
                if (mode_press) begin
                    state_n = ADJUST;
                    field_n = FLD_MIN;
                end
            end
            ADJUST: begin
                if (mode_press) begin
                    state_n = IDLE;
                    dir_n   = DIR_NONE;
                    rep_n   = '0;
                end else begin
                    if (right_press && !left_press) begin
                        field_n = (field == FLD_LAST) ? FLD_MIN : field + 4'd1;
                    end else if (left_press && !right_press) begin
                        field_n = (field == FLD_MIN) ? FLD_LAST : field - 4'd1;
                    end
                    if (up_lvl && down_lvl) begin
                        dir_n = DIR_NONE;
                        rep_n = '0;
                    end else if (up_press) begin
                        dir_n = DIR_UP;
                        rep_n = '0;
                        up_n  = 1'b1;
                    end else if (down_press) begin
                        dir_n  = DIR_DOWN;
                        rep_n  = '0;
                        down_n = 1'b1;
                    end else if ((dir == DIR_UP && up_lvl) || (dir == DIR_DOWN && down_lvl)) begin
                        if (rep_cnt == REP_LAST) begin
                            rep_n  = REP_RELOAD;
                            up_n   = (dir == DIR_UP);
                            down_n = (dir == DIR_DOWN);
                        end else begin
                            rep_n = rep_cnt + RW'(1);
                        end
                    end else begin
                        dir_n = DIR_NONE;
                        rep_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign adj_mode = (state == ADJUST);
    assign en_count = (state == ADJUST) ? field : FLD_NONE;

endmodule

// File: tb/tb_control_botones_ajuste.sv
// Directed self-checking bench for control_botones_ajuste with short debounce
// and repeat timings so every behaviour fits in a few hundred cycles.
module tb_control_botones_ajuste;

    logic       clk;
    logic       reset;
    logic       btn_up, btn_down, btn_left, btn_right, btn_mode;
    logic [3:0] en_count;
    logic       enUP, enDOWN, adj_mode;

    int compared   = 0;
    int mismatched = 0;

    control_botones_ajuste #(
        .DEB_CYCLES (4),
        .REP_DELAY  (20),
        .REP_PERIOD (5),
        .N_FIELDS   (9)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_mode  (btn_mode),
        .en_count  (en_count),
        .enUP      (enUP),
        .enDOWN    (enDOWN),
        .adj_mode  (adj_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic up, input logic down, input logic left,
                                 input logic right, input logic mode);
        btn_up    = up;
        btn_down  = down;
        btn_left  = left;
        btn_right = right;
        btn_mode  = mode;
    endtask

    task automatic checkValue(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_en, input logic exp_up,
                               input logic exp_down, input logic exp_adj);
        checkValue({tag, ".en_count"}, en_count, exp_en);
        checkValue({tag, ".enUP"},     {3'b0, enUP},     {3'b0, exp_up});
        checkValue({tag, ".enDOWN"},   {3'b0, enDOWN},   {3'b0, exp_down});
        checkValue({tag, ".adj_mode"}, {3'b0, adj_mode}, {3'b0, exp_adj});
    endtask

    // A clean edge reaches the registered outputs 2 + 4 + 1 = 7 clocks later;
    // a release needs 6 clocks to clear the debounced level.
    initial begin
        logic [3:0] right_seq [9];
        logic [3:0] left_seq  [4];
        logic [3:0] cur;
        logic       exp_up;

        right_seq = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
        left_seq  = '{4'd8, 4'd7, 4'd6, 4'd5};

        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        tick(3);
        checkOutput("reset", 4'd0, 0, 0, 0);
        reset = 1'b1;
        tick(5);
        checkOutput("after_reset", 4'd0, 0, 0, 0);

        $display("[TB] mode glitches then a real press");
        for (int g = 0; g < 2; g++) begin
            applyStimulus(0, 0, 0, 0, 1);
            tick(3);
            applyStimulus(0, 0, 0, 0, 0);
            tick(3);
        end
        tick(6);
        checkOutput("glitch_ignored", 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        tick(6);
        checkOutput("mode_latency", 4'd0, 0, 0, 0);
        tick(1);
        checkOutput("mode_enter", 4'd1, 0, 0, 1);
        tick(3);
        applyStimulus(0, 0, 0, 0, 0);
        tick(10);
        checkOutput("mode_single", 4'd1, 0, 0, 1);

        $display("[TB] right walk with wrap, then left wrap");
        cur = 4'd1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            tick(6);
            checkOutput("right_before", cur, 0, 0, 1);
            tick(1);
            checkOutput("right_after", right_seq[i], 0, 0, 1);
            cur = right_seq[i];
            applyStimulus(0, 0, 0, 0, 0);
            tick(8);
        end
        applyStimulus(0, 0, 1, 0, 0);
        tick(7);
        checkOutput("left_wrap", 4'd9, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        tick(8);

        $display("[TB] hold up for repeat");
        applyStimulus(1, 0, 0, 0, 0);
        tick(7);
        checkOutput("up_first", 4'd9, 1, 0, 1);
        // Released in cycle 59; the level is still high through cycle 64,
        // so the last repeat pulse is the one at t0+65.
        for (int k = 1; k <= 75; k++) begin
            tick(1);
            exp_up = (k >= 20) && (k <= 65) && ((k - 20) % 5 == 0);
            checkOutput("up_repeat", 4'd9, exp_up, 0, 1);
            if (k == 59) applyStimulus(0, 0, 0, 0, 0);
        end

        $display("[TB] up and down together");
        applyStimulus(1, 1, 0, 0, 0);
        for (int k = 0; k < 70; k++) begin
            tick(1);
            checkOutput("both_held", 4'd9, 0, 0, 1);
        end
        applyStimulus(1, 0, 0, 0, 0);
        for (int k = 0; k < 30; k++) begin
            tick(1);
            checkOutput("down_released", 4'd9, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 0);
        tick(10);

        $display("[TB] reset dropped while adjusting with up held");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, 0);
            tick(7);
            checkOutput("left_step", left_seq[i], 0, 0, 1);
            applyStimulus(0, 0, 0, 0, 0);
            tick(8);
        end
        applyStimulus(1, 0, 0, 0, 0);
        tick(7);
        checkOutput("pre_reset_pulse", 4'd5, 1, 0, 1);
        tick(4);
        checkOutput("pre_reset_hold", 4'd5, 0, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 4'd0, 0, 0, 0);
        tick(3);
        reset = 1'b1;
        tick(20);
        checkOutput("post_reset_idle", 4'd0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        tick(7);
        checkOutput("post_reset_enter", 4'd1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        for (int k = 0; k < 30; k++) begin
            tick(1);
            checkOutput("held_no_pulse", 4'd1, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 0);
        tick(10);
        applyStimulus(1, 0, 0, 0, 0);
        tick(7);
        checkOutput("repress_pulse", 4'd1, 1, 0, 1);
        tick(1);
        checkOutput("repress_single", 4'd1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        tick(10);

        $display("[TB] buttons ignored in idle; mode beats right");
        applyStimulus(0, 0, 0, 0, 1);
        tick(7);
        checkOutput("mode_exit", 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        tick(8);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(b == 0, b == 1, b == 2, b == 3, 0);
            for (int k = 0; k < 10; k++) begin
                tick(1);
                checkOutput("idle_ignore", 4'd0, 0, 0, 0);
            end
            applyStimulus(0, 0, 0, 0, 0);
            tick(8);
        end
        applyStimulus(0, 0, 0, 0, 1);
        tick(7);
        checkOutput("reenter", 4'd1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        tick(8);
        applyStimulus(0, 0, 0, 1, 0);
        tick(7);
        checkOutput("right_to_2", 4'd2, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        tick(8);
        applyStimulus(0, 0, 0, 1, 1);
        tick(7);
        checkOutput("mode_wins", 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        tick(8);
        applyStimulus(0, 0, 0, 0, 1);
        tick(7);
        checkOutput("final_enter", 4'd1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        tick(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
